// File: rtl/slewrate_bank_sequencer.sv
// rtl/slewrate_bank_sequencer.sv - applies per-bank slew-rate enable changes one bank at a time with settle gaps
module slewrate_bank_sequencer #(
    parameter int                   NUM_BANKS     = 6,
    parameter int                   SETTLE_CYCLES = 16,
    parameter logic [NUM_BANKS-1:0] RESET_VAL     = '0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_BANKS-1:0]         REQ_EN,
    input  logic                         HOLD,
    output logic [NUM_BANKS-1:0]         SLEWRATEEN,
    output logic [$clog2(NUM_BANKS)-1:0] CUR_BANK,
    output logic                         BUSY,
    output logic                         DONE
);

    localparam int BW = $clog2(NUM_BANKS);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 1");
    end
    if (NUM_BANKS < 2 || NUM_BANKS > 16) begin : g_bad_banks
        $error("NUM_BANKS must be in 2..16");
    end

    typedef enum logic [1:0] {IDLE, SCAN, APPLY, SETTLE} state_t;

    state_t                state;
    logic [BW-1:0]         rr_ptr;
    logic [CW-1:0]         settle_cnt;
    logic [NUM_BANKS-1:0]  mismatch;
    logic [NUM_BANKS-1:0]  rotated;
    logic [BW-1:0]         offset;
    logic [BW:0]           bank_sum;
    logic [BW-1:0]         next_bank;

    assign mismatch = REQ_EN ^ SLEWRATEEN;

    // Rotate so the round-robin pointer lands on bit 0, take the lowest set bit, then rotate back.
    always_comb begin
        rotated = NUM_BANKS'({mismatch, mismatch} >> rr_ptr);
        offset  = '0;
        for (int k = NUM_BANKS - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                offset = BW'(k);
            end
        end
        bank_sum = {1'b0, rr_ptr} + {1'b0, offset};
        if (bank_sum >= (BW+1)'(NUM_BANKS)) begin
            next_bank = BW'(bank_sum - (BW+1)'(NUM_BANKS));
        end else begin
            next_bank = bank_sum[BW-1:0];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            SLEWRATEEN <= RESET_VAL;
            state      <= IDLE;
            CUR_BANK   <= '0;
            rr_ptr     <= '0;
            settle_cnt <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (mismatch != '0 && !HOLD) begin
                        state <= SCAN;
                        BUSY  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (mismatch == '0 || HOLD) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end else begin
                        CUR_BANK <= next_bank;
                        state    <= APPLY;
                    end
                end
                APPLY: begin
                    // Re-sampled here: a reverted request makes this a no-op that still settles.
                    SLEWRATEEN[CUR_BANK] <= REQ_EN[CUR_BANK];
                    rr_ptr     <= (CUR_BANK == BW'(NUM_BANKS - 1)) ? '0 : CUR_BANK + BW'(1);
                    settle_cnt <= CW'(SETTLE_CYCLES - 1);
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - CW'(1);
                    end else if (mismatch != '0 && !HOLD) begin
                        state <= SCAN;
                    end else begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                        DONE  <= (mismatch == '0);
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slewrate_bank_sequencer.sv
// tb/tb_slewrate_bank_sequencer.sv - table, directed and random checks of slewrate_bank_sequencer
module tb_slewrate_bank_sequencer;

    localparam int N = 6;
    localparam int S = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         hold;
    logic [N-1:0] en;
    logic [2:0]   cur;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    slewrate_bank_sequencer #(
        .NUM_BANKS(N), .SETTLE_CYCLES(S), .RESET_VAL('0)
    ) dut (
        .CLK(clk), .RST(rst), .REQ_EN(req), .HOLD(hold),
        .SLEWRATEEN(en), .CUR_BANK(cur), .BUSY(busy), .DONE(done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a sequence step is a numbered age (0 pick, 1 write, 2..S+1 settle window).
    logic [N-1:0] m_en;
    logic         m_active;
    logic         m_done;
    int           m_age;
    int           m_bank;
    int           m_ptr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_en <= '0; m_active <= 1'b0; m_done <= 1'b0;
            m_age <= 0; m_bank <= 0; m_ptr <= 0;
        end else begin
            logic [N-1:0] mis;
            int pick;
            mis    = req ^ m_en;
            m_done <= 1'b0;
            if (!m_active) begin
                if (mis != 0 && !hold) begin
                    m_active <= 1'b1;
                    m_age    <= 0;
                end
            end else if (m_age == 0) begin
                if (mis == 0 || hold) begin
                    m_active <= 1'b0;
                end else begin
                    pick = -1;
                    for (int k = 0; k < N; k++) begin
                        int idx;
                        idx = (m_ptr + k) % N;
                        if (pick < 0 && mis[idx]) pick = idx;
                    end
                    m_bank <= pick;
                    m_age  <= 1;
                end
            end else if (m_age == 1) begin
                m_en[m_bank] <= req[m_bank];
                m_ptr        <= (m_bank + 1) % N;
                m_age        <= 2;
            end else if (m_age < S + 1) begin
                m_age <= m_age + 1;
            end else if (mis != 0 && !hold) begin
                m_age <= 0;
            end else begin
                m_active <= 1'b0;
                m_done   <= (mis == 0);
            end
        end
    end

    logic [N-1:0] prev_en = '0;
    always @(negedge clk) begin
        if (!rst) begin
            chk("mon_en", en, m_en);
            chk("mon_busy", busy, m_active);
            chk("mon_done", done, m_done);
            chk("mon_cur", cur, m_bank);
            chk("mon_one_bit", ($countones(en ^ prev_en) <= 1), 1);
        end
        prev_en <= en;
    end

    typedef struct {
        logic [N-1:0] req;
        logic         hold;
        int           wait_cyc;
        logic [N-1:0] en;
        logic         busy;
        logic         done;
        int           cur;
    } vec_t;

    vec_t tbl[20];

    initial begin
        tbl[0]  = '{6'b000100, 1'b0,   1, 6'b000000, 1'b1, 1'b0, 0};
        tbl[1]  = '{6'b000100, 1'b0,   1, 6'b000000, 1'b1, 1'b0, 2};
        tbl[2]  = '{6'b000100, 1'b0,   1, 6'b000100, 1'b1, 1'b0, 2};
        tbl[3]  = '{6'b000100, 1'b0,  16, 6'b000100, 1'b0, 1'b1, 2};
        tbl[4]  = '{6'b000100, 1'b0,   1, 6'b000100, 1'b0, 1'b0, 2};
        tbl[5]  = '{6'b110100, 1'b0,   3, 6'b010100, 1'b1, 1'b0, 4};
        tbl[6]  = '{6'b110100, 1'b0,  18, 6'b110100, 1'b1, 1'b0, 5};
        tbl[7]  = '{6'b110100, 1'b0,  16, 6'b110100, 1'b0, 1'b1, 5};
        tbl[8]  = '{6'b110100, 1'b0,   1, 6'b110100, 1'b0, 1'b0, 5};
        tbl[9]  = '{6'b111111, 1'b1, 100, 6'b110100, 1'b0, 1'b0, 5};
        tbl[10] = '{6'b111111, 1'b0,   3, 6'b110101, 1'b1, 1'b0, 0};
        tbl[11] = '{6'b111111, 1'b0,  36, 6'b111111, 1'b1, 1'b0, 3};
        tbl[12] = '{6'b111111, 1'b0,  16, 6'b111111, 1'b0, 1'b1, 3};
        tbl[13] = '{6'b000000, 1'b0,   3, 6'b101111, 1'b1, 1'b0, 4};
        tbl[14] = '{6'b000000, 1'b1,  16, 6'b101111, 1'b0, 1'b0, 4};
        tbl[15] = '{6'b000000, 1'b1,  50, 6'b101111, 1'b0, 1'b0, 4};
        tbl[16] = '{6'b001101, 1'b0,   3, 6'b001111, 1'b1, 1'b0, 5};
        tbl[17] = '{6'b001101, 1'b0,  18, 6'b001101, 1'b1, 1'b0, 1};
        tbl[18] = '{6'b001101, 1'b0,  16, 6'b001101, 1'b0, 1'b1, 1};
        tbl[19] = '{6'b001101, 1'b0,   1, 6'b001101, 1'b0, 1'b0, 1};

        rst = 1'b1; req = '0; hold = 1'b0;
        @(negedge clk);
        chk("rst_en", en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cur", cur, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            req  = tbl[i].req;
            hold = tbl[i].hold;
            repeat (tbl[i].wait_cyc) @(negedge clk);
            chk($sformatf("tbl%0d_en", i), en, tbl[i].en);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].done);
            chk($sformatf("tbl%0d_cur", i), cur, tbl[i].cur);
        end

        // Request bank 4 and withdraw it while the pick is pending.
        req = 6'b011101;
        @(negedge clk);
        req = 6'b001101;
        repeat (6) begin
            @(negedge clk);
            chk("revert_scan_en", en, 6'b001101);
            chk("revert_scan_done", done, 0);
        end
        chk("revert_scan_busy", busy, 0);

        // Bank 2 is serviced first; bank 3's request is withdrawn during that settle.
        req = 6'b000001;
        repeat (4) @(negedge clk);
        chk("revert_settle_first", en, 6'b001001);
        chk("revert_settle_cur", cur, 2);
        req = 6'b001001;
        repeat (40) begin
            @(negedge clk);
            chk("revert_settle_bank3", en[3], 1);
        end
        chk("revert_settle_final", en, 6'b001001);
        chk("revert_settle_idle", busy, 0);

        // Asynchronous reset in the middle of a settle window.
        req = 6'b111111;
        repeat (6) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_en", en, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_cur", cur, 0);
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_done", done, 0);
        end

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0) req = req ^ N'(1 << $urandom_range(0, N - 1));
            if ($urandom_range(0, 199) == 0) req = N'($urandom);
            hold = ($urandom_range(0, 9) == 0);
        end
        hold = 1'b0;
        repeat (8 * (S + 2) + 10) @(negedge clk);
        chk("final_match", en, req);
        chk("final_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
